booth_seq_multiplier: RTL and testbench



---
 rtl/booth_seq_multiplier.sv | 117 +++++++++++
 tb/tb_booth_seq_multiplier.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_multiplier.sv
// Sequential signed radix-2 Booth multiplier: one add/subtract and shift per cycle,
// WIDTH iterations per product, start/done handshake.
module booth_seq_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   y
);

    localparam int unsigned ACC_W = WIDTH + 1;
    localparam int unsigned Y_W   = 2 * WIDTH;
    localparam int unsigned SH_W  = 2 * WIDTH + 2;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   m_q, m_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [Y_W-1:0]     y_q, y_d;

    logic [ACC_W-1:0]   acc_sum;
    logic [SH_W-1:0]    shifted;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    // One Booth step: recode {Q[0], q_m1}, then arithmetic shift of {ACC, Q, q_m1}
    always_comb begin
        acc_sum = acc_q;
        case ({q_q[0], qm1_q})
            2'b10:   acc_sum = acc_q - m_q;
            2'b01:   acc_sum = acc_q + m_q;
            default: acc_sum = acc_q;
        endcase
        shifted = {acc_sum[ACC_W-1], acc_sum, q_q};
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        y_d     = y_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = {a[WIDTH-1], a};
                    acc_d   = '0;
                    q_d     = b;
                    qm1_d   = 1'b0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = shifted[SH_W-1:WIDTH+1];
                q_d   = shifted[WIDTH:1];
                qm1_d = shifted[0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Low 2*WIDTH bits of the post-shift {ACC, Q}
                    y_d     = shifted[Y_W:1];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN) || (state_q == DONE);
    assign done  = (state_q == DONE);
    assign y     = y_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier: expected products are queued at issue
// and popped by a monitor on every done pulse.
module tb_booth_seq_multiplier;

    localparam int unsigned W  = 4;
    localparam int unsigned YW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ready;
    logic          busy;
    logic          done;
    logic [YW-1:0] y;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            done_cnt = 0;
    logic [YW-1:0] exp_q[$];

    booth_seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference: plain signed integer product truncated to the product width
    function automatic logic [YW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] z);
        int sx;
        int sz;
        sx = int'($signed(x));
        sz = int'($signed(z));
        return YW'(sx * sz);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        while (!ready && g < 50) begin
            tick();
            g++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    // Issue one operation; report edges until done and cycles with ready low
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output int rdy_low);
        wait_ready();
        a     = av;
        b     = bv;
        start = 1'b1;
        exp_q.push_back(ref_mul(av, bv));
        tick();
        start   = 1'b0;
        lat     = 1;
        rdy_low = ready ? 0 : 1;
        while (!done && lat < 50) begin
            tick();
            lat++;
            if (!ready) rdy_low++;
        end
        tick();
        check("ready_after_done", 32'(ready), 32'd1);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    initial begin
        logic [YW-1:0] e;
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_done: got y=0x%0h with no request outstanding at %0t", y, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("product", 32'(y), 32'(e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int rdy_low;
        int base;
        int gaps;
        int ca[5];
        int cb[5];
        int cy[5];
        ca = '{-8,  7, -8, 0, -1};
        cb = '{-8, -8,  7, 5, -1};
        cy = '{8'h40, 8'hC8, 8'hC8, 8'h00, 8'h01};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_done",  32'(done),  32'd0);
        check("reset_y",     32'(y),     32'd0);
        rst_n = 1'b1;
        tick();

        // 3 x -4 with latency and ready-low checks
        run_op(W'(3), W'(4'hC), lat, rdy_low);
        check("latency_edges", 32'(lat), 32'(W + 1));
        check("ready_low_cycles", 32'(rdy_low), 32'(W + 1));
        check("y_3x_m4", 32'(y), 32'h0F4);

        for (int i = 0; i < 5; i++) begin
            run_op(W'(ca[i]), W'(cb[i]), lat, rdy_low);
            check("corner_y", 32'(y), 32'(cy[i]));
        end

        // Exhaustive back-to-back, start held high, operands scrambled while busy
        base = done_cnt;
        wait_ready();
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = W'(i >> 4);
            b = W'(i);
            exp_q.push_back(ref_mul(a, b));
            tick();
            gaps = 0;
            while (!ready && gaps < 50) begin
                a = W'($urandom);
                b = W'($urandom);
                tick();
                gaps++;
            end
            check("issue_interval", 32'(gaps + 1), 32'(W + 2));
        end
        start = 1'b0;
        tick();
        tick();
        check("exhaustive_done_count", 32'(done_cnt - base), 32'd256);

        // Reset during the second RUN cycle aborts without a done pulse
        base = done_cnt;
        wait_ready();
        a     = W'(5);
        b     = W'(3);
        start = 1'b1;
        exp_q.push_back(ref_mul(a, b));
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_done",  32'(done),  32'd0);
        check("abort_y",     32'(y),     32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("abort_no_done", 32'(done_cnt - base), 32'd0);
        run_op(W'(2), W'(6), lat, rdy_low);
        check("y_2x6", 32'(y), 32'h00C);

        // Reset and start together: reset wins, start dropped
        rst_n = 1'b0;
        start = 1'b1;
        a     = W'(3);
        b     = W'(3);
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        check("rst_start_ready", 32'(ready), 32'd1);
        tick();
        check("rst_start_busy", 32'(busy), 32'd0);

        // Result holds while idle with wandering operands
        run_op(W'(3), W'(5), lat, rdy_low);
        check("y_3x5", 32'(y), 32'h00F);
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            tick();
            check("idle_y_hold", 32'(y), 32'h00F);
            check("idle_no_done", 32'(done), 32'd0);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
